// File: rtl/i2c_target_10b.sv
// 10-bit-address open-drain I2C target: ACKs OWN_ADDR, delivers written bytes, serves reads after repeated START.
// Optional SCL clock stretching with rx_ack/tx_valid handshakes when I2C_TARGET_STRETCH_EN is defined.
module i2c_target_10b #(
  parameter logic [9:0] OWN_ADDR    = 10'h2A5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_drive_low,
  output logic       scl_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det,
`ifdef I2C_TARGET_STRETCH_EN
  input  logic       rx_ack,
  input  logic       tx_valid,
`endif
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR1   = 4'd1;
  localparam logic [3:0] S_ACK1    = 4'd2;
  localparam logic [3:0] S_ADDR2   = 4'd3;
  localparam logic [3:0] S_ACK2    = 4'd4;
  localparam logic [3:0] S_WR_BYTE = 4'd5;
  localparam logic [3:0] S_WR_ACK  = 4'd6;
  localparam logic [3:0] S_ACK_RD  = 4'd7;
  localparam logic [3:0] S_RD_BYTE = 4'd8;
  localparam logic [3:0] S_RD_ACK  = 4'd9;
  localparam logic [3:0] S_IGNORE  = 4'd10;

  localparam logic [7:0] HDR_WR = {5'b11110, OWN_ADDR[9:8], 1'b0};
  localparam logic [7:0] HDR_RD = {5'b11110, OWN_ADDR[9:8], 1'b1};

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;
  logic [3:0]             state;
  logic [7:0]             shift;
  logic [7:0]             byte_in;
  logic [2:0]             bit_cnt;
  logic                   bit_done;
  logic                   addr10_match;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in  = {shift[6:0], sda_s};
  assign state_dbg = state;

  // Preset to 1 so reset release never looks like a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      bit_done      <= 1'b0;
      addr10_match  <= 1'b0;
      sda_drive_low <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      tx_req        <= 1'b0;
      addressed     <= 1'b0;
      start_det     <= 1'b0;
      stop_det      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_c) begin
        start_det     <= 1'b1;
        state         <= S_ADDR1;
        bit_cnt       <= '0;
        bit_done      <= 1'b0;
        sda_drive_low <= 1'b0;
        addressed     <= 1'b0;
      end else if (stop_c) begin
        stop_det      <= 1'b1;
        state         <= S_IDLE;
        bit_cnt       <= '0;
        bit_done      <= 1'b0;
        addr10_match  <= 1'b0;
        sda_drive_low <= 1'b0;
        addressed     <= 1'b0;
      end else begin
        case (state)
          S_ADDR1, S_ADDR2, S_WR_BYTE: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_done <= 1'b0;
                case (state)
                  S_ADDR1: begin
                    if (byte_in == HDR_WR) state <= S_ACK1;
                    else if (byte_in == HDR_RD && addr10_match) state <= S_ACK_RD;
                    else begin
                      state        <= S_IGNORE;
                      addr10_match <= 1'b0;
                    end
                  end
                  S_ADDR2: state <= (byte_in == OWN_ADDR[7:0]) ? S_ACK2 : S_IGNORE;
                  default: begin
                    rx_data  <= byte_in;
                    rx_valid <= 1'b1;
                    state    <= S_WR_ACK;
                  end
                endcase
              end
            end
          end
          // First fall pulls SDA low, the 9th rise arms release on the following fall.
          S_ACK1, S_ACK2, S_WR_ACK: begin
            if (scl_fall) begin
              if (bit_done) begin
                sda_drive_low <= 1'b0;
                bit_done      <= 1'b0;
                bit_cnt       <= '0;
                state         <= (state == S_ACK1) ? S_ADDR2 : S_WR_BYTE;
              end else begin
                sda_drive_low <= 1'b1;
              end
            end else if (scl_rise) begin
              bit_done <= 1'b1;
              if (state == S_ACK2) begin
                addr10_match <= 1'b1;
                addressed    <= 1'b1;
              end
            end
          end
          S_ACK_RD: begin
            if (scl_fall) begin
              sda_drive_low <= 1'b1;
            end else if (scl_rise) begin
              shift     <= tx_data;
              tx_req    <= 1'b1;
              addressed <= 1'b1;
              bit_cnt   <= '0;
              bit_done  <= 1'b0;
              state     <= S_RD_BYTE;
            end
          end
          // Eight falls drive the byte MSB first; the ninth releases SDA for the master's ACK.
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_done) begin
                sda_drive_low <= 1'b0;
                bit_done      <= 1'b0;
                state         <= S_RD_ACK;
              end else begin
                sda_drive_low <= ~shift[7];
                shift         <= {shift[6:0], 1'b0};
                bit_cnt       <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) bit_done <= 1'b1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                shift    <= tx_data;
                tx_req   <= 1'b1;
                bit_cnt  <= '0;
                bit_done <= 1'b0;
                state    <= S_RD_BYTE;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          default: sda_drive_low <= 1'b0;
        endcase
      end
    end
  end

`ifdef I2C_TARGET_STRETCH_EN
  logic wait_rx, wait_tx, need_stretch;

  assign need_stretch = (wait_rx & ~rx_ack) | (wait_tx & ~tx_valid);

  // Stretch only begins while SCL is already low, then holds until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_rx       <= 1'b0;
      wait_tx       <= 1'b0;
      scl_drive_low <= 1'b0;
    end else begin
      if (stop_c) wait_rx <= 1'b0;
      else if (rx_valid) wait_rx <= 1'b1;
      else if (rx_ack) wait_rx <= 1'b0;
      if (stop_c) wait_tx <= 1'b0;
      else if (tx_req) wait_tx <= 1'b1;
      else if (tx_valid) wait_tx <= 1'b0;
      scl_drive_low <= need_stretch & (~scl_s | scl_drive_low) & ~stop_c;
    end
  end
`else
  assign scl_drive_low = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_10b.sv
// Directed bench for i2c_target_10b: a bit-banged master on a wired-AND bus checks ACKs, data and strobes.
module tb_i2c_target_10b;
  localparam int Q = 8;
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_IGNORE = 4'd10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_drive_low, scl_drive_low;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid, tx_req, addressed, start_det, stop_det;
  logic [3:0] state_dbg;
`ifdef I2C_TARGET_STRETCH_EN
  logic       rx_ack = 1'b1;
  logic       tx_valid = 1'b1;
`endif

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, stretch_cnt = 0, both_cnt = 0;
  logic [7:0] exp_q[$];

  assign scl_i = scl_m & ~scl_drive_low;
  assign sda_i = sda_m & ~sda_drive_low;

  always #5 clk = ~clk;

  i2c_target_10b dut (
    .clk(clk),
    .rst(rst),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .sda_drive_low(sda_drive_low),
    .scl_drive_low(scl_drive_low),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_req(tx_req),
    .addressed(addressed),
    .start_det(start_det),
    .stop_det(stop_det),
`ifdef I2C_TARGET_STRETCH_EN
    .rx_ack(rx_ack),
    .tx_valid(tx_valid),
`endif
    .state_dbg(state_dbg)
  );

  always @(posedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_req) tx_cnt++;
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (scl_drive_low) stretch_cnt++;
    if (rx_valid && tx_req) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period: data set in the low phase, sampled mid-high, honouring clock stretch.
  task automatic m_bit(input logic b, output logic r);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    for (int k = 0; k < 2000 && scl_i !== 1'b1; k++) tick(1);
    if (scl_i !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL scl_release: scl_i=%b required 1", scl_i);
    end
    tick(Q);
    r = sda_i;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_read(output logic [7:0] b, input logic master_ack, input logic [7:0] next_tx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      b[i] = r;
    end
    tx_data = next_tx;
    m_bit(~master_ack, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({sda_drive_low, scl_drive_low, rx_valid, tx_req, addressed, start_det, stop_det} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {sda_drive_low, scl_drive_low, rx_valid, tx_req, addressed, start_det, stop_det});
    end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    checks++;
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_write();
    logic a1, a2, a3;
    int rx0, st0;
    rx0 = rx_cnt;
    st0 = stop_cnt;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA5, a2);
    exp_q.push_back(8'h5A);
    m_write(8'h5A, a3);
    checks++;
    if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL write_acks: got %b required 111", {a1, a2, a3}); end
    checks++;
    if (addressed !== 1'b1) begin errors++; $display("FAIL write_addressed: got %b required 1", addressed); end
    checks++;
    if (rx_data !== exp_q[0]) begin errors++; $display("FAIL write_rx_data: got %h required %h", rx_data, exp_q[0]); end
    void'(exp_q.pop_front());
    m_stop();
    tick(4);
    checks++;
    if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL write_rx_valid_count: got %0d required 1", rx_cnt - rx0); end
    checks++;
    if (stop_cnt - st0 != 1) begin errors++; $display("FAIL write_stop_det: got %0d required 1", stop_cnt - st0); end
    checks++;
    if (addressed !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL write_after_stop: addressed=%b state=%0d required 0/0", addressed, state_dbg);
    end
  endtask

  task automatic test_back_to_back();
    logic a1, a2, a3, a4;
    int rx0;
    rx0 = rx_cnt;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA5, a2);
    m_write(8'h11, a3);
    checks++;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_byte1: got %h required 11", rx_data); end
    m_write(8'hEE, a4);
    checks++;
    if ({a3, a4} !== 2'b11) begin errors++; $display("FAIL b2b_acks: got %b required 11", {a3, a4}); end
    checks++;
    if (rx_data !== 8'hEE || rx_cnt - rx0 != 2) begin
      errors++;
      $display("FAIL b2b_byte2: got %h count %0d required ee count 2", rx_data, rx_cnt - rx0);
    end
    m_stop();
    tick(4);
  endtask

  task automatic test_nack_addr();
    logic a1, a2, a3;
    int rx0;
    rx0 = rx_cnt;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA4, a2);
    checks++;
    if ({a1, a2} !== 2'b10) begin errors++; $display("FAIL nack_addr_acks: got %b required 10", {a1, a2}); end
    checks++;
    if (state_dbg !== ST_IGNORE) begin errors++; $display("FAIL nack_addr_state: got %0d required 10", state_dbg); end
    m_write(8'h33, a3);
    checks++;
    if (a3 !== 1'b0 || rx_cnt != rx0 || state_dbg !== ST_IGNORE) begin
      errors++;
      $display("FAIL nack_addr_ignored: ack=%b rx_pulses=%0d state=%0d required 0/0/10", a3, rx_cnt - rx0, state_dbg);
    end
    m_stop();
    tick(4);
    checks++;
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL nack_addr_stop: got %0d required 0", state_dbg); end
  endtask

  task automatic test_read();
    logic a1, a2, a3;
    logic [7:0] d1, d2;
    int tx0, s0;
    tx0 = tx_cnt;
    s0 = start_cnt;
    tx_data = 8'hC3;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA5, a2);
    m_start();
    checks++;
    if (addressed !== 1'b0 || start_cnt - s0 != 2) begin
      errors++;
      $display("FAIL read_rstart: addressed=%b starts=%0d required 0/2", addressed, start_cnt - s0);
    end
    m_write(8'hF5, a3);
    checks++;
    if ({a1, a2, a3} !== 3'b111 || addressed !== 1'b1) begin
      errors++;
      $display("FAIL read_addr: acks=%b addressed=%b required 111/1", {a1, a2, a3}, addressed);
    end
    m_read(d1, 1'b1, 8'h0F);
    m_read(d2, 1'b0, 8'h00);
    checks++;
    if (d1 !== 8'hC3) begin errors++; $display("FAIL read_byte1: got %h required c3", d1); end
    checks++;
    if (d2 !== 8'h0F) begin errors++; $display("FAIL read_byte2: got %h required 0f", d2); end
    checks++;
    if (tx_cnt - tx0 != 2) begin errors++; $display("FAIL read_tx_req_count: got %0d required 2", tx_cnt - tx0); end
    checks++;
    if (sda_drive_low !== 1'b0 || state_dbg !== ST_IGNORE) begin
      errors++;
      $display("FAIL read_after_nack: sda_drive_low=%b state=%0d required 0/10", sda_drive_low, state_dbg);
    end
    m_stop();
    tick(4);
  endtask

  task automatic test_read_unaddressed();
    logic a1;
    int tx0;
    tx0 = tx_cnt;
    m_start();
    m_write(8'hF5, a1);
    checks++;
    if (a1 !== 1'b0 || tx_cnt != tx0) begin
      errors++;
      $display("FAIL read_unaddressed: ack=%b tx_req=%0d required 0/0", a1, tx_cnt - tx0);
    end
    checks++;
    if (state_dbg !== ST_IGNORE) begin errors++; $display("FAIL read_unaddr_state: got %0d required 10", state_dbg); end
    m_stop();
    tick(4);
  endtask

  task automatic test_partial_stop();
    logic a1, a2, r;
    int rx0;
    logic [7:0] rx_before;
    rx0 = rx_cnt;
    rx_before = rx_data;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA5, a2);
    m_bit(1'b1, r);
    m_bit(1'b0, r);
    m_bit(1'b1, r);
    m_bit(1'b1, r);
    m_stop();
    tick(4);
    checks++;
    if (rx_data !== 8'hEE || rx_cnt != rx0) begin
      errors++;
      $display("FAIL partial_stop_data: got %h pulses %0d required ee/0 (before %h)", rx_data, rx_cnt - rx0, rx_before);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL partial_stop_state: got %0d required 0", state_dbg); end
  endtask

  task automatic test_reset_mid_ack();
    logic r;
    logic [7:0] hdr;
    hdr = 8'hF4;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(hdr[i], r);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    checks++;
    if (sda_drive_low !== 1'b1) begin errors++; $display("FAIL mid_ack_driving: got %b required 1", sda_drive_low); end
    rst = 1'b1;
    #1;
    checks++;
    if (sda_drive_low !== 1'b0 || scl_drive_low !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_ack_reset: sda=%b scl=%b state=%0d required 0/0/0", sda_drive_low, scl_drive_low, state_dbg);
    end
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

`ifdef I2C_TARGET_STRETCH_EN
  task automatic test_stretch();
    logic a1, a2, a3, a4;
    int s0;
    rx_ack = 1'b0;
    m_start();
    m_write(8'hF4, a1);
    m_write(8'hA5, a2);
    s0 = stretch_cnt;
    fork
      m_write(8'h11, a3);
      begin
        for (int k = 0; k < 2000 && rx_valid !== 1'b1; k++) tick(1);
        tick(50);
        rx_ack = 1'b1;
      end
    join
    checks++;
    if (stretch_cnt - s0 < 30 || stretch_cnt - s0 > 50) begin
      errors++;
      $display("FAIL stretch_len: got %0d required 30..50", stretch_cnt - s0);
    end
    m_write(8'h22, a4);
    checks++;
    if ({a1, a2, a3, a4} !== 4'b1111 || rx_data !== 8'h22) begin
      errors++;
      $display("FAIL stretch_xfer: acks=%b rx_data=%h required 1111/22", {a1, a2, a3, a4}, rx_data);
    end
    m_stop();
    tick(4);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_nack_addr();
    test_read();
    test_read_unaddressed();
    test_partial_stop();
    test_reset_mid_ack();
`ifdef I2C_TARGET_STRETCH_EN
    test_stretch();
`endif
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL rx_tx_overlap: got %0d required 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_10b.md
Name: i2c_target_10b

Overview:
- 10-bit-address I2C target (slave) that sits downstream of the team's I2C master driver on the same SCL/SDA pair; used as the on-chip endpoint and as the bus-side responder in master-driver system benches.
- Decodes 10-bit addressing, ACKs its own address, and delivers written bytes to a local consumer.
- Serves read data from a local producer after a repeated START.
- Open-drain: never drives a bus line high, only pulls it low.

Parameters:
OWN_ADDR, 10'h2A5, target's 10-bit address
SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (min 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
scl_i  input  1  SCL as seen on the bus (asynchronous)
sda_i  input  1  SDA as seen on the bus (asynchronous)
sda_drive_low  output  1  1 = pull SDA low, 0 = release
scl_drive_low  output  1  1 = hold SCL low (clock stretch); constant 0 without macro
rx_data  output  8  last byte written by master
rx_valid  output  1  one-cycle pulse when rx_data updates
tx_data  input  8  byte to transmit; sampled when tx_req pulses
tx_req  output  1  one-cycle pulse when tx_data is captured
addressed  output  1  high from own-address ACK until STOP/START
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP

Behaviour:
- Reset (asynchronous, clk is the only clock):
  - Every output is 0. State is IDLE. Synchronisers are preset to 1.
  - The addr10_match flag is 0.
  - Reset asserted mid-transfer releases both lines on the same edge.
- Edge detection: runs on the synchronised signals scl_s/sda_s, compared against their previous values.
  - START: sda_s falls while scl_s = 1.
  - STOP: sda_s rises while scl_s = 1.
  - Bit sample: scl_s rising.
  - Drive change: scl_s falling.
- START and STOP override every state:
  - START goes to ADDR1 and clears the bit counter.
  - STOP goes to IDLE, clears addr10_match and releases both lines.
  - Neither START nor STOP produces rx_valid for a partial byte.
- States:
  - IDLE: wait for START.
  - ADDR1: shift 8 bits, MSB first.
    - If byte = {5'b11110, OWN_ADDR[9:8], 0}: go to ACK1.
    - If byte = {5'b11110, OWN_ADDR[9:8], 1} and addr10_match = 1: go to ACK_RD.
    - Any other byte: go to IGNORE.
  - ACK1: pull SDA low from the falling edge after bit 8 to the falling edge after the 9th clock. Then go to ADDR2.
  - ADDR2: shift 8 bits.
    - If byte = OWN_ADDR[7:0]: go to ACK2.
    - Otherwise: go to IGNORE with SDA released, so the master sees a NACK.
  - ACK2: ACK as in ACK1. Set addr10_match and addressed, then go to WR_BYTE.
  - WR_BYTE: shift 8 bits into the shift register. On the 8th rising edge, rx_data <= shift and rx_valid pulses. Go to WR_ACK.
  - WR_ACK: ACK as in ACK1, then go to WR_BYTE. This supports unlimited sequential bytes.
  - ACK_RD: ACK as in ACK1. Set addressed, and pulse tx_req in the cycle tx_data is loaded into the shift register (at the ACK's rising edge). Go to RD_BYTE.
  - RD_BYTE:
    - On each falling edge, drive the current MSB: pull low if 0, release if 1. Shift left.
    - After the 8th bit's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on the rising edge.
    - Low (ACK): pulse tx_req, load the next tx_data, go to RD_BYTE.
    - High (NACK): go to IGNORE.
  - IGNORE: lines released. Wait for START or STOP.
- Bit counter: 3 bits plus done flag. It wraps to 0 after every ACK slot.
- START in ACK1/ACK2/WR_ACK while SDA is low: not possible on a legal bus. If the master forces it anyway, release SDA and go to ADDR1.
- Repeated START after ACK2 keeps addr10_match. Repeated START followed by a non-matching ADDR1 byte clears it.
- rx_valid and tx_req are never asserted in the same cycle.
- Latency: bus edge to internal action = SYNC_STAGES + 1 clk cycles.
- Timing requirement: clk must be at least 16x the SCL frequency.

Optional Feature:
- Macro: I2C_TARGET_STRETCH_EN.
- With the macro:
  - After each rx_valid, scl_drive_low asserts on the next scl_s low and stays asserted until an extra input rx_ack (1 bit, port added under the macro) is seen high for one cycle.
  - After each tx_req, SCL is held the same way until tx_valid (1 bit, also added under the macro) is high.
  - Release happens the cycle after the handshake.
- Without the macro: scl_drive_low is constant 0, the rx_ack/tx_valid ports do not exist, and the target never stretches.

Test Plan:
1. Write 0x5A to 0x2A5 (bytes 0xF4, 0xA5, 0x5A, STOP) -> SDA low in all three ACK slots; rx_data = 0x5A with one rx_valid pulse; stop_det pulses; addressed falls.
2. Address 0x2A4 (0xF4, 0xA4) -> ACK on byte 1, NACK on byte 2; no rx_valid; state IGNORE until STOP.
3. Read: 0xF4, 0xA5, repeated START, 0xF5; tx_data = 0xC3 then 0x0F; master ACKs byte 1 and NACKs byte 2 -> bus bits 11000011 then 00001111; exactly two tx_req pulses; SDA released after the NACK.
4. 0xF5 after STOP with no prior write addressing -> NACK; tx_req never pulses.
5. STOP after 4 bits of a data byte -> IDLE; rx_data unchanged; no rx_valid. Reset asserted mid-ACK -> sda_drive_low = 0 immediately.
6. Stretch (macro on): write 2 bytes, hold rx_ack low for 50 cycles -> SCL held low 50 cycles after byte 1; the transfer resumes and completes with correct rx_data.
